// File: rtl/riscv_selfcheck_monitor_if.sv
// Snoop bus between the core and the self-check monitor: register-file write port, fetch
// validity and program counter.
interface riscv_selfcheck_monitor_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
);
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            instr_valid;
  logic [PC_W-1:0] pc;

  modport master (output rf_we, rf_waddr, rf_wdata, instr_valid, pc);
  modport slave  (input  rf_we, rf_waddr, rf_wdata, instr_valid, pc);
endinterface

// File: rtl/riscv_selfcheck_monitor.sv
// Self-check monitor: scores in-program tests seen on the register-file write port.
// Optional macro SELFCHECK_STOP_ON_FAIL_EN: first failing compare ends the run and raises halt_req.
module riscv_selfcheck_monitor #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned PC_W            = 32,
  parameter int unsigned MEM_WORDS       = 256,
  parameter int unsigned TESTID_REG      = 1,
  parameter int unsigned ACTUAL_REG      = 29,
  parameter int unsigned EXPECT_REG      = 30,
  parameter int unsigned STROBE_REG      = 31,
  parameter int unsigned STROBE_VAL      = 1,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned LOG_DEPTH       = 8,
  parameter int unsigned END_IDLE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 100000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  riscv_selfcheck_monitor_if.slave  core,
  output logic                      running,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [XLEN-1:0]           cur_test_id,
  output logic [CNT_W-1:0]          check_count,
  output logic [CNT_W-1:0]          fail_count,
  input  logic                      log_rd_en,
  output logic                      log_valid,
  output logic [XLEN-1:0]           log_test_id,
  output logic [CNT_W-1:0]          log_dropped
`ifdef SELFCHECK_STOP_ON_FAIL_EN
  ,
  output logic                      halt_req
`endif
);

  localparam int unsigned LogAw = $clog2(LOG_DEPTH);
  localparam int unsigned PtrW  = LogAw + 1;
  localparam int unsigned IdleW = $clog2(END_IDLE_CYCLES + 1);
  localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(END_IDLE_CYCLES - 1);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYCLES - 1);
  localparam logic [PC_W:0]    EndAddr  = (PC_W + 1)'(MEM_WORDS * 4);

  typedef enum logic [1:0] {StIdle, StRun, StCheck, StDone} state_e;

  state_e              state_q;
  logic [XLEN-1:0]     tid_q, act_q, exp_q;
  logic [CNT_W-1:0]    check_q, fail_q, drop_q;
  logic [IdleW-1:0]    idle_q;
  logic [WdogW-1:0]    wdog_q;
  logic                timeout_q;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [XLEN-1:0]     log_mem [LOG_DEPTH];
`ifdef SELFCHECK_STOP_ON_FAIL_EN
  logic                halt_q;
`endif

  logic active, wr_ok, trigger, idle_hit, pc_hit, wdog_hit, end_hit;
  logic mismatch, empty, full, pop, push;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    active   = (state_q == StRun) || (state_q == StCheck);
    // Address 0 is never a valid target, whatever the register parameters say.
    wr_ok    = core.rf_we && (core.rf_waddr != 5'd0);
    trigger  = active && wr_ok && (core.rf_waddr == 5'(STROBE_REG))
               && (core.rf_wdata == XLEN'(STROBE_VAL));
    idle_hit = !core.instr_valid && (idle_q >= IdleLast);
    pc_hit   = {1'b0, core.pc} >= EndAddr;
    wdog_hit = wdog_q >= WdogLast;
    end_hit  = idle_hit || pc_hit || wdog_hit;
    mismatch = (state_q == StCheck) && (act_q != exp_q);
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = ((wr_ptr_q - rd_ptr_q) == PtrW'(LOG_DEPTH));
    pop      = log_rd_en && !empty;
    push     = mismatch && (!full || pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      tid_q     <= '0;
      act_q     <= '0;
      exp_q     <= '0;
      check_q   <= '0;
      fail_q    <= '0;
      drop_q    <= '0;
      idle_q    <= '0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
`ifdef SELFCHECK_STOP_ON_FAIL_EN
      halt_q    <= 1'b0;
`endif
    end else begin
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q   <= StRun;
            tid_q     <= '0;
            act_q     <= '0;
            exp_q     <= '0;
            check_q   <= '0;
            fail_q    <= '0;
            drop_q    <= '0;
            idle_q    <= '0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
`ifdef SELFCHECK_STOP_ON_FAIL_EN
            halt_q    <= 1'b0;
`endif
          end
        end
        StRun, StCheck: begin
          if (wr_ok && core.rf_waddr == 5'(TESTID_REG)) tid_q <= core.rf_wdata;
          if (wr_ok && core.rf_waddr == 5'(ACTUAL_REG)) act_q <= core.rf_wdata;
          if (wr_ok && core.rf_waddr == 5'(EXPECT_REG)) exp_q <= core.rf_wdata;
          if (core.instr_valid)    idle_q <= '0;
          else if (idle_q < IdleLast) idle_q <= idle_q + IdleW'(1);
          if (wdog_q < WdogLast) wdog_q <= wdog_q + WdogW'(1);
          // Every CHECK cycle compares the shadows as they stood before this edge.
          if (state_q == StCheck) begin
            check_q <= sat_inc(check_q);
            if (mismatch)          fail_q <= sat_inc(fail_q);
            if (mismatch && !push) drop_q <= sat_inc(drop_q);
          end
`ifdef SELFCHECK_STOP_ON_FAIL_EN
          if (mismatch) begin
            state_q <= StDone;
            halt_q  <= 1'b1;
          end else
`endif
          if (trigger) begin
            state_q <= StCheck;
          end else if (end_hit) begin
            state_q <= StDone;
            if (wdog_hit) timeout_q <= 1'b1;
          end else begin
            state_q <= StRun;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Log storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) log_mem[wr_ptr_q[LogAw-1:0]] <= tid_q;
  end

  always_comb begin
    running     = active;
    done        = (state_q == StDone);
    pass        = done && (fail_q == '0) && (check_q != '0) && !timeout_q;
    timeout     = timeout_q;
    cur_test_id = tid_q;
    check_count = check_q;
    fail_count  = fail_q;
    log_dropped = drop_q;
    log_valid   = !empty;
    log_test_id = empty ? '0 : log_mem[rd_ptr_q[LogAw-1:0]];
`ifdef SELFCHECK_STOP_ON_FAIL_EN
    halt_req    = halt_q;
`endif
  end

endmodule

// File: tb/tb_riscv_selfcheck_monitor.sv
// Directed bench for riscv_selfcheck_monitor with a failure-log scoreboard and a second
// instance configured for a short watchdog.
module tb_riscv_selfcheck_monitor;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned PC_W      = 32;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned LOG_DEPTH = 8;
  localparam int unsigned MEM_WORDS = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic log_rd_en = 1'b0;
  always #5 clk = ~clk;

  riscv_selfcheck_monitor_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

  logic            running, done, pass, timeout, log_valid;
  logic [XLEN-1:0] cur_test_id, log_test_id;
  logic [CNT_W-1:0] check_count, fail_count, log_dropped;
  logic            wd_running, wd_done, wd_pass, wd_timeout, wd_log_valid;
  logic [XLEN-1:0] wd_cur_test_id, wd_log_test_id;
  logic [CNT_W-1:0] wd_check_count, wd_fail_count, wd_log_dropped;
`ifdef SELFCHECK_STOP_ON_FAIL_EN
  logic            halt_req, wd_halt_req;
`endif

  riscv_selfcheck_monitor #(.TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .reset(reset), .start(start), .core(bus),
    .running(running), .done(done), .pass(pass), .timeout(timeout),
    .cur_test_id(cur_test_id), .check_count(check_count), .fail_count(fail_count),
    .log_rd_en(log_rd_en), .log_valid(log_valid), .log_test_id(log_test_id),
    .log_dropped(log_dropped)
`ifdef SELFCHECK_STOP_ON_FAIL_EN
    , .halt_req(halt_req)
`endif
  );

  riscv_selfcheck_monitor #(.TIMEOUT_CYCLES(50)) dut_wd (
    .clk(clk), .reset(reset), .start(start), .core(bus),
    .running(wd_running), .done(wd_done), .pass(wd_pass), .timeout(wd_timeout),
    .cur_test_id(wd_cur_test_id), .check_count(wd_check_count),
    .fail_count(wd_fail_count), .log_rd_en(1'b0), .log_valid(wd_log_valid),
    .log_test_id(wd_log_test_id), .log_dropped(wd_log_dropped)
`ifdef SELFCHECK_STOP_ON_FAIL_EN
    , .halt_req(wd_halt_req)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int exp_checks = 0;
  int exp_fails  = 0;
  int exp_drop   = 0;
  logic [XLEN-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rf_write(input logic [4:0] addr, input logic [XLEN-1:0] data);
    bus.rf_we    = 1'b1;
    bus.rf_waddr = addr;
    bus.rf_wdata = data;
    tick();
    bus.rf_we    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_checks = 0;
    exp_fails  = 0;
    exp_drop   = 0;
    exp_q.delete();
  endtask

  // Drives one in-program test and records what the monitor must report for it.
  task automatic do_check(input logic [XLEN-1:0] tid, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] e);
    rf_write(5'd1, tid);
    rf_write(5'd29, a);
    rf_write(5'd30, e);
    rf_write(5'd31, 32'd1);
    exp_checks++;
    if (a != e) begin
      exp_fails++;
      if (exp_q.size() < LOG_DEPTH) exp_q.push_back(tid);
      else exp_drop++;
    end
  endtask

  task automatic check_counts(input string tag);
    chk({tag, ".check_count"}, 64'(check_count), 64'(exp_checks));
    chk({tag, ".fail_count"},  64'(fail_count),  64'(exp_fails));
    chk({tag, ".log_dropped"}, 64'(log_dropped), 64'(exp_drop));
  endtask

  task automatic pop_log(input string tag);
    chk({tag, ".log_valid"}, 64'(log_valid), 64'd1);
    if (exp_q.size() > 0) chk({tag, ".log_test_id"}, 64'(log_test_id), 64'(exp_q.pop_front()));
    log_rd_en = 1'b1;
    tick();
    log_rd_en = 1'b0;
  endtask

  task automatic go_idle(input string tag);
    bus.instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk({tag, ".done_early"}, 64'(done), 64'd0);
    tick();
    chk({tag, ".done"}, 64'(done), 64'd1);
    bus.instr_valid = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: observed running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    bus.rf_we = 1'b0; bus.rf_waddr = '0; bus.rf_wdata = '0;
    bus.instr_valid = 1'b1; bus.pc = 32'h100;
    #3 reset = 1'b0;
    tick(); tick();
    chk("rst.running", 64'(running), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.pass", 64'(pass), 64'd0);
    chk("rst.timeout", 64'(timeout), 64'd0);
    chk("rst.check_count", 64'(check_count), 64'd0);
    chk("rst.log_valid", 64'(log_valid), 64'd0);
    chk("rst.log_test_id", 64'(log_test_id), 64'd0);
    reset = 1'b1;
    tick();

    // Single passing check, then end of program by idle fetch.
    pulse_start();
    chk("t1.running", 64'(running), 64'd1);
    do_check(32'd1, 32'd5, 32'd5);
    tick();
    check_counts("t1");
    go_idle("t1");
    chk("t1.pass", 64'(pass), 64'd1);
    chk("t1.log_valid", 64'(log_valid), 64'd0);

`ifdef SELFCHECK_STOP_ON_FAIL_EN
    pulse_start();
    do_check(32'd6, 32'd1, 32'd2);
    tick();
    chk("stop.halt_req", 64'(halt_req), 64'd1);
    chk("stop.done", 64'(done), 64'd1);
    check_counts("stop");
    rf_write(5'd31, 32'd1);
    tick();
    chk("stop.later_strobe", 64'(check_count), 64'd1);
    pop_log("stop");
    pulse_start();
    chk("stop.halt_clear", 64'(halt_req), 64'd0);
`else
    // One failing check, logged and popped.
    pulse_start();
    chk("t2.cleared", 64'(check_count), 64'd0);
    do_check(32'd3, 32'd7, 32'd8);
    tick();
    check_counts("t2");
    chk("t2.cur_test_id", 64'(cur_test_id), 64'd3);
    pop_log("t2");
    chk("t2.log_empty", 64'(log_valid), 64'd0);
    go_idle("t2");
    chk("t2.pass", 64'(pass), 64'd0);

    // Overfill the log, then push and pop together while full.
    pulse_start();
    for (int i = 0; i < 10; i++) do_check(32'(10 + i), 32'(i), 32'(i + 100));
    tick();
    check_counts("t3");
    rf_write(5'd1, 32'd20);
    rf_write(5'd29, 32'd1);
    rf_write(5'd30, 32'd2);
    rf_write(5'd31, 32'd1);
    chk("t3.head_before", 64'(log_test_id), 64'(exp_q.pop_front()));
    log_rd_en = 1'b1;
    tick();
    log_rd_en = 1'b0;
    exp_checks++;
    exp_fails++;
    exp_q.push_back(32'd20);
    check_counts("t3.full_rw");
    go_idle("t3");
    chk("t3.pass", 64'(pass), 64'd0);
    for (int i = 0; i < LOG_DEPTH && exp_q.size() > 0; i++) pop_log("t3.drain");
    chk("t3.log_empty", 64'(log_valid), 64'd0);

    // Back-to-back strobes and pre-edge shadow semantics.
    pulse_start();
    rf_write(5'd1, 32'd4);
    rf_write(5'd29, 32'd5);
    rf_write(5'd30, 32'd5);
    rf_write(5'd31, 32'd1);
    rf_write(5'd31, 32'd1);
    chk("t4.cc_first", 64'(check_count), 64'd1);
    rf_write(5'd29, 32'd9);
    chk("t4.cc_second", 64'(check_count), 64'd2);
    chk("t4.fc_second", 64'(fail_count), 64'd0);
    rf_write(5'd31, 32'd2);
    chk("t4.strobe_val2", 64'(check_count), 64'd2);
    rf_write(5'd31, 32'd1);
    tick();
    exp_checks = 3;
    exp_fails  = 1;
    exp_q.push_back(32'd4);
    check_counts("t4");
    pop_log("t4");
    go_idle("t4");
`endif

    // End of program by pc reaching the end of memory.
    pulse_start();
    bus.pc = 32'(MEM_WORDS * 4 - 4);
    tick();
    chk("t5.below_end", 64'(done), 64'd0);
    bus.pc = 32'(MEM_WORDS * 4);
    tick();
    chk("t5.done", 64'(done), 64'd1);
    chk("t5.timeout", 64'(timeout), 64'd0);
    bus.pc = 32'h100;

    // Watchdog on the short-timeout instance.
    pulse_start();
    for (int i = 0; i < 49; i++) tick();
    chk("t6.wd_done_early", 64'(wd_done), 64'd0);
    chk("t6.wd_timeout_early", 64'(wd_timeout), 64'd0);
    tick();
    chk("t6.wd_timeout", 64'(wd_timeout), 64'd1);
    chk("t6.wd_done", 64'(wd_done), 64'd1);
    chk("t6.wd_pass", 64'(wd_pass), 64'd0);
    chk("t6.main_running", 64'(running), 64'd1);

    // start ignored mid-run, then asynchronous reset discards everything.
    do_check(32'd7, 32'd5, 32'd5);
    tick();
    chk("t7.cc", 64'(check_count), 64'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t7.start_ignored", 64'(check_count), 64'd1);
    chk("t7.still_running", 64'(running), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("t7.running", 64'(running), 64'd0);
    chk("t7.check_count", 64'(check_count), 64'd0);
    chk("t7.cur_test_id", 64'(cur_test_id), 64'd0);
    chk("t7.done", 64'(done), 64'd0);
    reset = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_selfcheck_monitor.md
Name: riscv_selfcheck_monitor

Overview:
- Synthesisable self-check monitor that snoops the core's register-file write port and scores in-program tests.
- Generalises the x31/x29/x30 convention: a strobe register triggers a compare of an "actual" register against an "expected" register, tagged with a test-id register.
- Adds pass/fail counters, a failure log FIFO, end-of-program detection and a watchdog.
- Sits beside MultipleInstructions; usable in simulation and on FPGA.

Parameters:
- XLEN, 32, register data width.
- PC_W, 32, program counter width.
- MEM_WORDS, 256, program memory size in words; end address is MEM_WORDS*4.
- TESTID_REG, 1, register index holding the current test number.
- ACTUAL_REG, 29, register index holding the as-is value.
- EXPECT_REG, 30, register index holding the benchmark value.
- STROBE_REG, 31, register index; writing STROBE_VAL triggers a check.
- STROBE_VAL, 1, trigger value.
- CNT_W, 16, width of all counters.
- LOG_DEPTH, 8, failure FIFO depth; power of two, at least 2.
- END_IDLE_CYCLES, 4, consecutive cycles with instr_valid low that mean end of program.
- TIMEOUT_CYCLES, 100000, watchdog limit in RUN cycles.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a run from IDLE or DONE.
- rf_we  in  1  register-file write enable.
- rf_waddr  in  5  write address.
- rf_wdata  in  XLEN  write data.
- instr_valid  in  1  fetched instruction is not X / invalid.
- pc  in  PC_W  current program counter.
- running  out  1  state is RUN or CHECK.
- done  out  1  state is DONE.
- pass  out  1  done, no failures, at least one check, no timeout.
- timeout  out  1  watchdog expired.
- cur_test_id  out  XLEN  shadow of TESTID_REG.
- check_count  out  CNT_W  checks performed.
- fail_count  out  CNT_W  checks that failed.
- log_rd_en  in  1  pops the failure FIFO.
- log_valid  out  1  FIFO not empty.
- log_test_id  out  XLEN  head entry (first-word-fall-through).
- log_dropped  out  CNT_W  failures not logged because the FIFO was full.

Behaviour:
- Reset (reset low, asynchronous):
  - state goes to IDLE.
  - All outputs, shadow registers, counters and FIFO pointers go to 0.
  - log_valid is 0.
- States:
  - IDLE: start goes to RUN and clears counters, shadows, FIFO and watchdog.
  - RUN: a trigger goes to CHECK. An end or timeout condition goes to DONE.
  - CHECK: performs the compare. A new trigger keeps the state in CHECK; otherwise end/timeout goes to DONE, else RUN.
  - DONE: holds all results. start performs a full clear and goes to RUN.
- Shadow registers:
  - In RUN/CHECK, an rf_we write whose rf_waddr matches TESTID/ACTUAL/EXPECT_REG updates that shadow at the edge.
  - Writes to address 0 are ignored, even if a parameter is set to 0.
- Trigger: rf_we && rf_waddr==STROBE_REG && rf_wdata==STROBE_VAL, while in RUN or CHECK.
- Compare latency:
  - A trigger sampled at edge N is compared at edge N+1, using the shadow values held before edge N+1.
  - check_count and fail_count are visible after edge N+1.
  - A shadow write at edge N+1 affects only later checks.
- Failure (actual !== expected):
  - fail_count increments.
  - cur_test_id is pushed to the FIFO.
  - If the FIFO is full, nothing is pushed and log_dropped increments instead.
- Counters saturate at all ones and never wrap.
- FIFO:
  - log_rd_en while empty is ignored.
  - Push and pop in the same cycle while full: both happen, so occupancy is unchanged.
  - Reads are allowed in every state.
- End conditions, evaluated only in RUN/CHECK:
  - instr_valid low for END_IDLE_CYCLES consecutive cycles; the idle counter resets when instr_valid is high.
  - pc >= MEM_WORDS*4.
- Watchdog:
  - Counts every RUN/CHECK cycle.
  - On reaching TIMEOUT_CYCLES: timeout=1 and go to DONE.
- A trigger pending in the same cycle as an end condition is still compared (via CHECK) before entering DONE.
- start while in RUN/CHECK is ignored.
- Reset mid-run discards everything.

Optional Feature:
- Macro: SELFCHECK_STOP_ON_FAIL_EN.
- Defined:
  - The first failing compare moves the state directly to DONE at the compare edge.
  - A sticky output halt_req (1 bit, reset 0) is asserted; it clears on start.
  - Later triggers are not evaluated.
- Undefined:
  - No halt_req port.
  - The run continues through all failures to the end condition.

Test Plan:
- Writes x29=5, x30=5, then x31=1, END_IDLE_CYCLES idle -> check_count=1, fail_count=0, done=1, pass=1, log_valid=0.
- Writes x1=3, x29=7, x30=8, x31=1 -> fail_count=1 one cycle after the strobe; log_test_id=3 and log_valid=1; one pop -> log_valid=0; pass=0 at done.
- 10 failing checks with LOG_DEPTH=8 -> fail_count=10, log_dropped=2, FIFO holds the first 8 test ids in order.
- x31 written on consecutive cycles with x29 changed between them -> each compare uses the pre-edge shadow; check_count=2 and the state passes CHECK->CHECK; x31=2 causes no check.
- pc set to MEM_WORDS*4 -> DONE next edge. TIMEOUT_CYCLES=50 with instr_valid held high -> timeout=1 and done after 50 cycles. reset pulled low mid-run -> all outputs 0 immediately, no clock edge required.
- With SELFCHECK_STOP_ON_FAIL_EN defined: one failing check -> halt_req=1, done=1; a later strobe does not change check_count.
